// File: rtl/arb_client_mux.sv
`default_nettype none
// ============================================================================
// Module      : arb_client_mux
// Description : N-requester client mux in front of an external arbiter; issues
//               granted requests downstream and routes in-order responses back
//               through an index FIFO. Optional starvation flags are enabled
//               with the ARB_CLIENT_STARVE_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_client_mux #(
    parameter int N     = 3,
    parameter int DW    = 32,
    parameter int RW    = 32,
    parameter int DEPTH = 4,
    parameter int TMO   = 255
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [N-1:0]           s_valid,
    input  logic [N*DW-1:0]        s_data,
    output logic [N-1:0]           s_ready,
    output logic [N-1:0]           arb_req,
    input  logic [N-1:0]           arb_gnt,
    output logic                   arb_upd,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DW-1:0]          m_data,
    input  logic                   m_rsp_valid,
    output logic                   m_rsp_ready,
    input  logic [RW-1:0]          m_rsp_data,
    output logic [N-1:0]           s_rsp_valid,
    input  logic [N-1:0]           s_rsp_ready,
    output logic [RW-1:0]          s_rsp_data,
    output logic [$clog2(DEPTH):0] outstanding,
`ifdef ARB_CLIENT_STARVE_EN
    output logic [N-1:0]           starve,
`endif
    output logic                   err
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_iw = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_aw:0] c_full_level = (c_aw + 1)'(DEPTH);

    logic [c_iw-1:0] r_order [DEPTH];
    logic [c_aw-1:0] r_wptr;
    logic [c_aw-1:0] r_rptr;
    logic [c_aw:0]   r_count;
    logic            r_m_valid;
    logic [DW-1:0]   r_m_data;
    logic            r_err;

    logic            w_full;
    logic            w_empty;
    logic            w_can_issue;
    logic [N-1:0]    w_req;
    logic            w_multi;
    logic            w_onehot;
    logic            w_outside;
    logic            w_accept;
    logic            w_pop;
    logic            w_err_set;
    logic [c_iw-1:0] w_gnt_idx;
    logic [c_iw-1:0] w_head;
    logic [DW-1:0]   w_gnt_data;

    assign w_full  = (r_count == c_full_level);
    assign w_empty = (r_count == '0);

    // rstn gates issue so every combinational output is quiet during reset
    assign w_can_issue = rstn && !w_full && (!r_m_valid || m_ready);
    assign w_req       = s_valid & {N{w_can_issue}};

    assign w_multi   = |(arb_gnt & (arb_gnt - N'(1)));
    assign w_onehot  = (|arb_gnt) && !w_multi;
    assign w_outside = |(arb_gnt & ~w_req);
    assign w_accept  = w_onehot && !w_outside && w_can_issue;

    always_comb begin
        w_gnt_idx  = '0;
        w_gnt_data = '0;
        for (int i = 0; i < N; i++) begin
            if (arb_gnt[i]) begin
                w_gnt_idx  = w_gnt_idx | c_iw'(i);
                w_gnt_data = w_gnt_data | s_data[i*DW +: DW];
            end
        end
    end

    assign arb_req = w_req;
    assign s_ready = arb_gnt & {N{w_accept}};
    assign arb_upd = w_accept;
    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;

    assign w_head      = r_order[r_rptr];
    assign m_rsp_ready = !w_empty && s_rsp_ready[w_head];
    assign w_pop       = m_rsp_valid && m_rsp_ready;
    assign s_rsp_data  = w_empty ? '0 : m_rsp_data;

    always_comb begin
        s_rsp_valid = '0;
        if (!w_empty) begin
            s_rsp_valid[w_head] = m_rsp_valid;
        end
    end

    assign w_err_set   = w_multi || w_outside || (m_rsp_valid && w_empty);
    assign err         = r_err;
    assign outstanding = r_count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_m_valid <= 1'b1;
                r_m_data  <= w_gnt_data;
            end else if (m_ready) begin
                r_m_valid <= 1'b0;
            end
            if (w_accept) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    // Entries need no reset: the pointers define which ones are live
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_order[r_wptr] <= w_gnt_idx;
        end
    end

`ifdef ARB_CLIENT_STARVE_EN
    localparam int c_cw = $clog2(TMO + 2);
    localparam logic [c_cw-1:0] c_tmo = c_cw'(TMO);

    logic [c_cw-1:0] r_starve_cnt [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_starve
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_starve_cnt[gi] <= '0;
            end else if (!s_valid[gi] || s_ready[gi]) begin
                r_starve_cnt[gi] <= '0;
            end else if (r_starve_cnt[gi] < c_tmo) begin
                r_starve_cnt[gi] <= r_starve_cnt[gi] + 1'b1;
            end
        end
        assign starve[gi] = (r_starve_cnt[gi] >= c_tmo);
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_arb_client_mux.sv
`default_nettype none
// Randomized scoreboard bench for arb_client_mux: a transaction-level model
// predicts accepts and order, a monitor checks the downstream and return paths.
module tb_arb_client_mux;
    localparam int N     = 3;
    localparam int DW    = 32;
    localparam int RW    = 32;
    localparam int DEPTH = 4;
    localparam int TMO   = 4;

    logic                   clk;
    logic                   rstn;
    logic [N-1:0]           s_valid;
    logic [N*DW-1:0]        s_data;
    logic [N-1:0]           s_ready;
    logic [N-1:0]           arb_req;
    logic [N-1:0]           arb_gnt;
    logic                   arb_upd;
    logic                   m_valid;
    logic                   m_ready;
    logic [DW-1:0]          m_data;
    logic                   m_rsp_valid;
    logic                   m_rsp_ready;
    logic [RW-1:0]          m_rsp_data;
    logic [N-1:0]           s_rsp_valid;
    logic [N-1:0]           s_rsp_ready;
    logic [RW-1:0]          s_rsp_data;
    logic [$clog2(DEPTH):0] outstanding;
    logic                   err;
`ifdef ARB_CLIENT_STARVE_EN
    logic [N-1:0]           starve;
    int                     st_cnt [N];
`endif

    arb_client_mux #(.N(N), .DW(DW), .RW(RW), .DEPTH(DEPTH), .TMO(TMO)) dut (
        .clk(clk), .rstn(rstn),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .arb_req(arb_req), .arb_gnt(arb_gnt), .arb_upd(arb_upd),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready), .m_rsp_data(m_rsp_data),
        .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready), .s_rsp_data(s_rsp_data),
        .outstanding(outstanding),
`ifdef ARB_CLIENT_STARVE_EN
        .starve(starve),
`endif
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // External arbiter: 0 = rotating legal pick, 1 = forced & arb_req, 2 = raw forced
    int         gnt_mode = 0;
    logic [N-1:0] gnt_force = '0;
    int         rot = 0;

    always_comb begin
        arb_gnt = '0;
        if (gnt_mode == 1) begin
            arb_gnt = gnt_force & arb_req;
        end else if (gnt_mode == 2) begin
            arb_gnt = gnt_force;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (arb_req[(k + rot) % N] && (arb_gnt == '0)) arb_gnt[(k + rot) % N] = 1'b1;
            end
        end
    end

    // Reference model state and scoreboard queues
    int            mdl_q[$];
    bit            mdl_mv = 0;
    bit            mdl_err = 0;
    logic [DW-1:0] sb_data[$];
    int            sb_idx[$];

    bit            e_can;
    bit            e_outside;
    bit            e_acc;
    int            e_pc;
    int            e_idx;
    logic [N-1:0]  e_req;
    logic [N-1:0]  e_rdy;

    initial forever begin
        @(negedge clk);
        #1;
        if (!rstn) begin
            chk("rst_arb_req", arb_req, 0);
            chk("rst_s_ready", s_ready, 0);
            chk("rst_arb_upd", arb_upd, 0);
            chk("rst_m_valid", m_valid, 0);
            chk("rst_m_data", m_data, 0);
            chk("rst_m_rsp_ready", m_rsp_ready, 0);
            chk("rst_s_rsp_valid", s_rsp_valid, 0);
            chk("rst_s_rsp_data", s_rsp_data, 0);
            chk("rst_outstanding", outstanding, 0);
            chk("rst_err", err, 0);
`ifdef ARB_CLIENT_STARVE_EN
            chk("rst_starve", starve, 0);
            for (int i = 0; i < N; i++) st_cnt[i] = 0;
`endif
            mdl_q.delete();
            sb_data.delete();
            sb_idx.delete();
            mdl_mv  = 0;
            mdl_err = 0;
        end else begin
            e_can     = (mdl_q.size() < DEPTH) && (!mdl_mv || m_ready);
            e_req     = e_can ? s_valid : '0;
            e_pc      = $countones(arb_gnt);
            e_outside = (arb_gnt & ~e_req) != '0;
            e_acc     = (e_pc == 1) && !e_outside && e_can;
            e_rdy     = e_acc ? arb_gnt : '0;
            chk("arb_req", arb_req, e_req);
            chk("s_ready", s_ready, e_rdy);
            chk("arb_upd", arb_upd, e_acc);
            chk("m_valid", m_valid, mdl_mv);
            chk("outstanding", outstanding, mdl_q.size());
            chk("err", err, mdl_err);
`ifdef ARB_CLIENT_STARVE_EN
            for (int i = 0; i < N; i++) begin
                chk($sformatf("starve%0d", i), starve[i], st_cnt[i] >= TMO);
                if (!s_valid[i] || e_rdy[i]) st_cnt[i] = 0;
                else st_cnt[i]++;
            end
`endif
            if (e_pc > 1 || e_outside || (m_rsp_valid && mdl_q.size() == 0)) mdl_err = 1;
            if (mdl_q.size() > 0 && m_rsp_valid && s_rsp_ready[mdl_q[0]]) void'(mdl_q.pop_front());
            if (e_acc) begin
                e_idx = 0;
                for (int i = 0; i < N; i++) if (arb_gnt[i]) e_idx = i;
                mdl_q.push_back(e_idx);
                sb_idx.push_back(e_idx);
                sb_data.push_back(s_data[e_idx*DW +: DW]);
                mdl_mv = 1;
            end else if (m_ready) begin
                mdl_mv = 0;
            end
        end
    end

    // Monitor: checks whatever the DUT presents against the scoreboard heads
    int           mon_h;
    logic [N-1:0] mon_v;

    initial forever begin
        @(negedge clk);
        if (rstn) begin
            if (m_valid) begin
                if (sb_data.size() == 0) begin
                    chk("m_valid_unexpected", m_valid, 1'b0);
                end else begin
                    chk("m_data", m_data, sb_data[0]);
                    if (m_ready) void'(sb_data.pop_front());
                end
            end
            if (sb_idx.size() > 0) begin
                mon_h = sb_idx[0];
                mon_v = '0;
                mon_v[mon_h] = m_rsp_valid;
                chk("s_rsp_valid", s_rsp_valid, mon_v);
                chk("m_rsp_ready", m_rsp_ready, s_rsp_ready[mon_h]);
                chk("s_rsp_data", s_rsp_data, m_rsp_data);
                if (m_rsp_valid && s_rsp_ready[mon_h]) void'(sb_idx.pop_front());
            end else begin
                chk("s_rsp_valid_empty", s_rsp_valid, 0);
                chk("m_rsp_ready_empty", m_rsp_ready, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) s_data[k*DW +: DW] = $urandom;
        m_rsp_data = $urandom;
        rot = $urandom_range(0, N - 1);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        s_valid = '0;
        m_rsp_valid = 1'b0;
        gnt_mode = 0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        s_valid = '0;
        s_data = '0;
        m_ready = 1'b0;
        m_rsp_valid = 1'b0;
        m_rsp_data = '0;
        s_rsp_ready = '0;
        repeat (3) tick();
        rstn = 1'b1;

        // Single accept of requester 0 out of two valid
        s_valid = 3'b011; gnt_mode = 1; gnt_force = 3'b001; m_ready = 1'b1;
        tick();
        s_valid = '0; gnt_force = '0;
        repeat (2) tick();

        // Downstream stall holds data and blocks issue
        do_reset();
        s_valid = 3'b111; gnt_mode = 0; m_ready = 1'b0;
        repeat (6) tick();
        m_ready = 1'b1; s_valid = '0;
        repeat (2) tick();

        // Fill order FIFO with 2,0,1,2 then drain responses in order
        do_reset();
        s_valid = 3'b111; m_ready = 1'b1; gnt_mode = 1;
        gnt_force = 3'b100; tick();
        gnt_force = 3'b001; tick();
        gnt_force = 3'b010; tick();
        gnt_force = 3'b100; tick();
        gnt_mode = 0;
        repeat (3) tick();
        s_valid = '0; s_rsp_ready = 3'b111; m_rsp_valid = 1'b1;
        s_rsp_ready = 3'b011; tick();
        s_rsp_ready = 3'b111;
        repeat (4) tick();
        m_rsp_valid = 1'b0;
        tick();

        // Reset with work in flight, then immediate accept
        do_reset();
        s_valid = 3'b001; m_ready = 1'b1;
        repeat (2) tick();
        m_ready = 1'b0; s_valid = '0;
        tick();
        rstn = 1'b0; s_valid = 3'b111; m_rsp_valid = 1'b1;
        repeat (2) tick();
        rstn = 1'b1; m_rsp_valid = 1'b0; s_valid = 3'b001; m_ready = 1'b1;
        tick();
        s_valid = '0;
        tick();

        // Requester 1 held without grant
        do_reset();
        s_valid = 3'b010; gnt_mode = 1; gnt_force = '0;
        repeat (6) tick();
        s_valid = '0;
        tick();

        // Multi-hot grant sets sticky error
        do_reset();
        s_valid = 3'b011; gnt_mode = 2; gnt_force = 3'b011;
        tick();
        gnt_mode = 0; s_valid = '0;
        repeat (3) tick();

        // Grant outside the request vector
        do_reset();
        s_valid = 3'b001; gnt_mode = 2; gnt_force = 3'b010;
        tick();
        gnt_mode = 0; s_valid = '0;
        repeat (2) tick();

        // Response with nothing outstanding
        do_reset();
        m_rsp_valid = 1'b1; s_rsp_ready = 3'b111;
        tick();
        m_rsp_valid = 1'b0;
        repeat (2) tick();

        // Randomized traffic with occasional reset
        do_reset();
        for (int c = 0; c < 600; c++) begin
            s_valid = N'($urandom);
            m_ready = ($urandom_range(0, 3) != 0);
            s_rsp_ready = N'($urandom);
            m_rsp_valid = (mdl_q.size() > 0) && ($urandom_range(0, 1) == 1);
            rstn = ($urandom_range(0, 149) != 0);
            tick();
        end
        rstn = 1'b1;
        s_valid = '0;
        m_rsp_valid = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
